// File: rtl/bram_channel_arbiter_if.sv
// bram_channel_arbiter_if: channel request/response and BRAM port B signals of the arbiter
interface bram_channel_arbiter_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic [NUM_CH-1:0]          wr_req;
  logic [NUM_CH*DATA_W-1:0]   wr_data;
  logic [NUM_CH*DATA_W/8-1:0] wr_be;
  logic [NUM_CH-1:0]          wr_ack;
  logic [NUM_CH-1:0]          rd_req;
  logic [NUM_CH*DATA_W-1:0]   rd_data;
  logic [NUM_CH-1:0]          rd_valid;
  logic [ADDR_W-1:0]          addrb;
  logic                       clkb;
  logic                       rstb;
  logic [DATA_W-1:0]          dinb;
  logic [DATA_W-1:0]          doutb;
  logic                       enb;
  logic [DATA_W/8-1:0]        web;
  modport master (
    input  wr_req, wr_data, wr_be, rd_req, doutb,
    output wr_ack, rd_data, rd_valid, addrb, clkb, rstb, dinb, enb, web
  );
  modport slave (
    output wr_req, wr_data, wr_be, rd_req, doutb,
    input  wr_ack, rd_data, rd_valid, addrb, clkb, rstb, dinb, enb, web
  );
endinterface

// File: rtl/bram_channel_arbiter.sv
// bram_channel_arbiter: round-robin multi-channel BRAM port B master with pipelined reads
module bram_channel_arbiter #(
  parameter int                NUM_CH     = 4,
  parameter int                DATA_W     = 32,
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h4000_0000,
  parameter int                STRIDE     = 4,
  parameter int                RD_LATENCY = 1
) (
  input logic A_CLK,
  input logic A_RESETN,
  bram_channel_arbiter_if.master bus
);
  localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam int BW = DATA_W / 8;
  typedef struct packed {
    logic          v;
    logic [CW-1:0] ch;
  } rd_tag_t;
  rd_tag_t [RD_LATENCY:0] pipe;
  logic [CW-1:0] ptr, gnt, idx;
  logic gnt_v, gnt_wr;
  logic [NUM_CH-1:0] tog, rd_busy, wr_el, rd_el, elig;
  assign bus.clkb = A_CLK;
  assign bus.rstb = ~A_RESETN;
  // a channel stays read-busy from issue through its rd_valid cycle
  always_comb begin
    rd_busy = bus.rd_valid;
    for (int i = 0; i <= RD_LATENCY; i++)
      if (pipe[i].v) rd_busy[pipe[i].ch] = 1'b1;
  end
  assign wr_el = bus.wr_req & ~bus.wr_ack;
  assign rd_el = bus.rd_req & ~rd_busy;
  assign elig  = wr_el | rd_el;
  // descending scan so the lowest offset from ptr wins
  always_comb begin
    gnt_v = 1'b0;
    gnt   = '0;
    idx   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      idx = CW'((int'(ptr) + i) % NUM_CH);
      if (elig[idx]) begin
        gnt_v = 1'b1;
        gnt   = idx;
      end
    end
    gnt_wr = wr_el[gnt] & (~rd_el[gnt] | ~tog[gnt]);
  end
  always_ff @(posedge A_CLK) begin
    if (!A_RESETN) begin
      ptr          <= '0;
      tog          <= '0;
      pipe         <= '0;
      bus.enb      <= 1'b0;
      bus.web      <= '0;
      bus.dinb     <= '0;
      bus.addrb    <= '0;
      bus.wr_ack   <= '0;
      bus.rd_valid <= '0;
      bus.rd_data  <= '0;
    end else begin
      bus.enb      <= gnt_v;
      bus.web      <= gnt_v && gnt_wr ? bus.wr_be[gnt*BW +: BW] : '0;
      bus.dinb     <= gnt_v && gnt_wr ? bus.wr_data[gnt*DATA_W +: DATA_W] : '0;
      bus.wr_ack   <= gnt_v && gnt_wr ? NUM_CH'(1) << gnt : '0;
      pipe         <= {pipe[RD_LATENCY-1:0], rd_tag_t'{gnt_v & ~gnt_wr, gnt}};
      bus.rd_valid <= '0;
      if (gnt_v) begin
        bus.addrb <= BASE_ADDR + ADDR_W'(STRIDE * int'(gnt));
        ptr       <= gnt == CW'(NUM_CH - 1) ? '0 : gnt + 1'b1;
        tog[gnt]  <= ~tog[gnt];
      end
      if (pipe[RD_LATENCY].v) begin
        bus.rd_valid[pipe[RD_LATENCY].ch]                    <= 1'b1;
        bus.rd_data[pipe[RD_LATENCY].ch*DATA_W +: DATA_W] <= bus.doutb;
      end
    end
  end
endmodule

// File: tb/tb_bram_channel_arbiter.sv
// tb_bram_channel_arbiter: vector table plus scoreboard bench with a BRAM model of latency 2
module tb_bram_channel_arbiter;
  localparam int L = 2;
  logic clk = 1'b0;
  logic rst_n;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  bram_channel_arbiter_if #(.NUM_CH(4), .DATA_W(32), .ADDR_W(32)) bus ();
  bram_channel_arbiter #(.RD_LATENCY(L)) dut (.A_CLK(clk), .A_RESETN(rst_n), .bus(bus));
  logic [31:0] mem [4] = '{default: '0};
  logic [31:0] dp [L];
  logic [31:0] off;
  assign off = bus.addrb - 32'h4000_0000;
  assign bus.doutb = dp[L-1];
  always @(posedge clk) begin
    if (bus.enb) begin
      for (int b = 0; b < 4; b++)
        if (bus.web[b]) mem[off[3:2]][b*8 +: 8] <= bus.dinb[b*8 +: 8];
      dp[0] <= mem[off[3:2]];
    end
    for (int i = 1; i < L; i++) dp[i] <= dp[i-1];
  end
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  typedef struct { logic [31:0] addr; logic [3:0] be; logic [31:0] data; } wr_exp_t;
  typedef struct { int ch; logic [31:0] data; } rd_exp_t;
  wr_exp_t wr_q[$];
  rd_exp_t rd_q[$];
  wr_exp_t wm;
  rd_exp_t rm;
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.wr_ack != 0) begin
        if (wr_q.size() == 0) chk("wr_unexpected", bus.wr_ack, 0);
        else begin
          wm = wr_q.pop_front();
          chk("wr_enb", bus.enb, 1);
          chk("wr_addr", bus.addrb, wm.addr);
          chk("wr_web", bus.web, wm.be);
          chk("wr_dinb", bus.dinb, wm.data);
        end
      end
      for (int k = 0; k < 4; k++)
        if (bus.rd_valid[k]) begin
          if (rd_q.size() == 0) chk("rd_unexpected", bus.rd_valid, 0);
          else begin
            rm = rd_q.pop_front();
            chk("rd_ch", k, rm.ch);
            chk("rd_data", bus.rd_data[k*32 +: 32], rm.data);
          end
        end
    end
  end
  typedef struct { int ch; logic [31:0] data; logic [3:0] be; logic [31:0] addr; logic [3:0] ack; } wvec_t;
  typedef struct { int ch; logic [31:0] data; } rvec_t;
  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    wvec_t wv [5];
    rvec_t rv [4];
    logic [31:0] exp_rd [4];
    logic [7:0] op [1:5];
    logic vld5;
    int n;
    wv[0] = '{2, 32'hDEAD_BEEF, 4'b0101, 32'h4000_0008, 4'b0100};
    wv[1] = '{0, 32'hA5A5_1234, 4'b1111, 32'h4000_0000, 4'b0001};
    wv[2] = '{3, 32'hFFFF_FFFF, 4'b0000, 32'h4000_000C, 4'b1000};
    wv[3] = '{1, 32'h1234_5678, 4'b1111, 32'h4000_0004, 4'b0010};
    wv[4] = '{2, 32'h1122_3344, 4'b1010, 32'h4000_0008, 4'b0100};
    rv[0] = '{1, 32'h1234_5678};
    rv[1] = '{2, 32'h11AD_33EF};
    rv[2] = '{0, 32'hA5A5_1234};
    rv[3] = '{3, 32'h0000_0000};
    exp_rd = '{default: '0};
    bus.wr_req = '1;
    bus.rd_req = '1;
    bus.wr_data = '0;
    bus.wr_be = '0;
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_enb", bus.enb, 0);
    chk("rst_wr_ack", bus.wr_ack, 0);
    chk("rst_rd_valid", bus.rd_valid, 0);
    chk("rst_rd_data", bus.rd_data, 0);
    chk("rst_rstb", bus.rstb, 1);
    bus.wr_req = '0;
    bus.rd_req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      bus.wr_req[wv[i].ch] = 1'b1;
      bus.wr_data[wv[i].ch*32 +: 32] = wv[i].data;
      bus.wr_be[wv[i].ch*4 +: 4] = wv[i].be;
      wr_q.push_back('{wv[i].addr, wv[i].be, wv[i].data});
      n = 0;
      do begin @(negedge clk); n++; end while (!bus.wr_ack[wv[i].ch] && n < 10);
      chk("wr_latency", n, 1);
      chk("wr_ack", bus.wr_ack, wv[i].ack);
      bus.wr_req[wv[i].ch] = 1'b0;
      @(negedge clk);
      chk("wr_ack_pulse", bus.wr_ack, 0);
      chk("wr_enb_idle", bus.enb, 0);
    end
    for (int i = 0; i < 4; i++) begin
      bus.rd_req[rv[i].ch] = 1'b1;
      rd_q.push_back('{rv[i].ch, rv[i].data});
      exp_rd[rv[i].ch] = rv[i].data;
      n = 0;
      do begin @(negedge clk); n++; end while (!bus.rd_valid[rv[i].ch] && n < 20);
      chk("rd_latency", n, L + 2);
      bus.rd_req[rv[i].ch] = 1'b0;
      for (int k = 0; k < 4; k++) chk("rd_slot", bus.rd_data[k*32 +: 32], exp_rd[k]);
      @(negedge clk);
      chk("rd_valid_pulse", bus.rd_valid, 0);
    end
    do_reset(2);
    bus.wr_data[31:0] = 32'hCAFE_F00D;
    bus.wr_be[3:0] = 4'hF;
    bus.wr_req[0] = 1'b1;
    bus.rd_req[0] = 1'b1;
    repeat (3) wr_q.push_back('{32'h4000_0000, 4'hF, 32'hCAFE_F00D});
    rd_q.push_back('{0, 32'hCAFE_F00D});
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      op[c] = !bus.enb ? "-" : (bus.wr_ack[0] ? "W" : "R");
    end
    vld5 = bus.rd_valid[0];
    bus.wr_req = '0;
    bus.rd_req = '0;
    chk("alt_op1", op[1], "W");
    chk("alt_op2", op[2], "R");
    chk("alt_op3", op[3], "W");
    chk("alt_op4", op[4], "-");
    chk("alt_op5", op[5], "W");
    chk("alt_rd_valid", vld5, 1);
    @(negedge clk);
    chk("alt_idle", bus.enb, 0);
    do_reset(2);
    for (int k = 0; k < 4; k++) begin
      bus.wr_data[k*32 +: 32] = 32'hC0DE_0000 | k;
      bus.wr_be[k*4 +: 4] = 4'hF;
    end
    for (int c = 0; c < 5; c++) wr_q.push_back('{32'h4000_0000 + 4 * (c % 4), 4'hF, 32'hC0DE_0000 | (c % 4)});
    bus.wr_req = '1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      chk("rr_enb", bus.enb, 1);
      chk("rr_ack", bus.wr_ack, 4'b0001 << ((c - 1) % 4));
    end
    bus.wr_req = '0;
    @(negedge clk);
    chk("rr_idle", bus.enb, 0);
    bus.rd_req[3] = 1'b1;
    @(negedge clk);
    chk("rst_rd_issue", bus.enb, 1);
    chk("rst_rd_addr", bus.addrb, 32'h4000_000C);
    @(negedge clk);
    rst_n = 1'b0;
    bus.rd_req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("rst_rd_novalid", bus.rd_valid, 0);
    end
    chk("rst_rd_slot3", bus.rd_data[127:96], 0);
    chk("wr_q_empty", wr_q.size(), 0);
    chk("rd_q_empty", rd_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
